// File: rtl/disp_scan_sched.sv
// disp_scan_sched: 4-digit multiplexed display anode scanner.
// Optional inter-digit dark gap is compiled in with `define DISP_SCAN_BLANK_EN.
module disp_scan_sched #(
  parameter int DIV   = 100000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] digit_mask,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       frame_tick
);
  typedef enum logic [1:0] {S_IDLE, S_ON, S_BLANK} state_t;

  localparam logic [19:0] DIV_LAST = 20'(DIV - 1);
  // Out-of-range parameters keep the scanner held in reset, so no digit ever lights.
  localparam logic PARAMS_OK = (DIV >= 2) && (DIV <= 1048575) && (BLANK >= 1) && (BLANK <= 255);

  state_t      state_reg;
  logic [19:0] dwell_cnt_reg;
`ifdef DISP_SCAN_BLANK_EN
  localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);
  logic [7:0]  blank_cnt_reg;
`endif
  logic [1:0]  sel_reg;
  logic [3:0]  an_reg;
  logic        tick_reg;
  logic [1:0]  rst_sync_reg;

  logic [3:0]  rot_mask;
  logic [2:0]  step;
  logic [2:0]  step_sum;
  logic [1:0]  sel_next;
  logic [1:0]  first_sel;
  logic        wrap_next;
  logic        mask_any;

  assign sel        = sel_reg;
  assign an         = an_reg;
  assign frame_tick = tick_reg;
  assign mask_any   = |digit_mask;

  // Assert asynchronously, release only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], PARAMS_OK};
  end

  // rot_mask[k] is the mask bit k+1 positions above the current digit (mod 4).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_mask[gi] = digit_mask[sel_reg + 2'(gi + 1)];
    end
  endgenerate

  always_comb begin
    step      = 3'd4;
    first_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_mask[i])   step      = 3'(i + 1);
      if (digit_mask[i]) first_sel = 2'(i);
    end
    // Carry out of the 2-bit index means the new digit is at or below the old one.
    step_sum  = {1'b0, sel_reg} + step;
    sel_next  = step_sum[1:0];
    wrap_next = step_sum[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      sel_reg       <= 2'd0;
      an_reg        <= 4'hF;
      tick_reg      <= 1'b0;
      dwell_cnt_reg <= '0;
`ifdef DISP_SCAN_BLANK_EN
      blank_cnt_reg <= '0;
`endif
    end else if (!rst_sync_reg[1]) begin
      state_reg     <= S_IDLE;
      sel_reg       <= 2'd0;
      an_reg        <= 4'hF;
      tick_reg      <= 1'b0;
      dwell_cnt_reg <= '0;
`ifdef DISP_SCAN_BLANK_EN
      blank_cnt_reg <= '0;
`endif
    end else if (!en) begin
      state_reg     <= S_IDLE;
      an_reg        <= 4'hF;
      tick_reg      <= 1'b0;
      dwell_cnt_reg <= '0;
`ifdef DISP_SCAN_BLANK_EN
      blank_cnt_reg <= '0;
`endif
    end else begin
      tick_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          an_reg <= 4'hF;
          if (mask_any) begin
            state_reg     <= S_ON;
            sel_reg       <= first_sel;
            an_reg        <= ~(4'b0001 << first_sel);
            dwell_cnt_reg <= '0;
          end
        end
        S_ON: begin
          if (dwell_cnt_reg == DIV_LAST) begin
            dwell_cnt_reg <= '0;
`ifdef DISP_SCAN_BLANK_EN
            state_reg     <= S_BLANK;
            an_reg        <= 4'hF;
            blank_cnt_reg <= '0;
`else
            if (mask_any) begin
              sel_reg  <= sel_next;
              an_reg   <= ~(4'b0001 << sel_next);
              tick_reg <= wrap_next;
            end else begin
              state_reg <= S_IDLE;
              an_reg    <= 4'hF;
            end
`endif
          end else begin
            dwell_cnt_reg <= dwell_cnt_reg + 20'd1;
          end
        end
`ifdef DISP_SCAN_BLANK_EN
        S_BLANK: begin
          if (blank_cnt_reg == BLANK_LAST) begin
            blank_cnt_reg <= '0;
            if (mask_any) begin
              state_reg <= S_ON;
              sel_reg   <= sel_next;
              an_reg    <= ~(4'b0001 << sel_next);
              tick_reg  <= wrap_next;
            end else begin
              state_reg <= S_IDLE;
            end
          end else begin
            blank_cnt_reg <= blank_cnt_reg + 8'd1;
          end
        end
`endif
        default: begin
          state_reg <= S_IDLE;
          an_reg    <= 4'hF;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_disp_scan_sched.sv
// Directed bench for disp_scan_sched with DIV=4, BLANK=2; follows whichever
// build (DISP_SCAN_BLANK_EN defined or not) it is compiled against.
module tb_disp_scan_sched;
  localparam int DIV   = 4;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] digit_mask = 4'h0;
  logic [1:0] sel;
  logic [3:0] an;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  disp_scan_sched #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_mask (digit_mask),
    .sel        (sel),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {frame_tick, sel, an} packed into one word
  function automatic logic [31:0] obs();
    return {25'd0, frame_tick, sel, an};
  endfunction

  function automatic logic [31:0] pack(input logic t, input logic [1:0] s, input logic [3:0] a);
    return {25'd0, t, s, a};
  endfunction

  // Called at a negedge on the first lit cycle of digit d; returns at the
  // negedge of the first cycle of the following digit (or idle).
  task automatic expect_digit(input string tag, input int d, input bit tk);
    logic [1:0] ds;
    logic [3:0] lit;
    ds  = 2'(d);
    lit = 4'b0001;
    lit = ~(lit << ds);
    for (int i = 0; i < DIV; i++) begin
      check($sformatf("%s on d%0d c%0d", tag, d, i), obs(), pack(tk && (i == 0), ds, lit));
      @(negedge clk);
    end
`ifdef DISP_SCAN_BLANK_EN
    for (int i = 0; i < BLANK; i++) begin
      check($sformatf("%s blank d%0d c%0d", tag, d, i), obs(), pack(1'b0, ds, 4'hF));
      @(negedge clk);
    end
`endif
  endtask

  task automatic wait_lit(input string tag);
    int n;
    n = 0;
    while (an == 4'hF && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, " lit"}, {31'd0, an != 4'hF}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset state", obs(), pack(1'b0, 2'd0, 4'hF));
    en = 1'b1;
    digit_mask = 4'hF;
    @(negedge clk);
    check("reset held with en", obs(), pack(1'b0, 2'd0, 4'hF));
    rst_n = 1'b1;
    @(negedge clk);
    check("sync first edge dark", obs(), pack(1'b0, 2'd0, 4'hF));
    wait_lit("release");
    $display("phase: full mask scan");
    expect_digit("f1", 0, 1'b0);
    expect_digit("f1", 1, 1'b0);
    expect_digit("f1", 2, 1'b0);
    expect_digit("f1", 3, 1'b0);
    expect_digit("f2", 0, 1'b1);
    expect_digit("f2", 1, 1'b0);
    expect_digit("f2", 2, 1'b0);
    expect_digit("f2", 3, 1'b0);

    $display("phase: mask 1010");
    digit_mask = 4'b1010;
    expect_digit("m1010", 0, 1'b1);
    expect_digit("m1010", 1, 1'b0);
    expect_digit("m1010", 3, 1'b0);
    expect_digit("m1010", 1, 1'b1);
    expect_digit("m1010", 3, 1'b0);
    expect_digit("m1010", 1, 1'b1);

    $display("phase: mask 0100");
    digit_mask = 4'b0100;
    expect_digit("m0100", 3, 1'b0);
    expect_digit("m0100", 2, 1'b1);
    expect_digit("m0100", 2, 1'b1);

    $display("phase: mask cleared mid-dwell");
    digit_mask = 4'b0010;
    expect_digit("m0010", 2, 1'b1);
    digit_mask = 4'b0000;
    expect_digit("clr", 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idle c%0d", i), obs(), pack(1'b0, 2'd1, 4'hF));
      @(negedge clk);
    end
    digit_mask = 4'b0001;
    @(negedge clk);
    expect_digit("restore", 0, 1'b0);

    $display("phase: single digit, then en low");
    digit_mask = 4'b1000;
    expect_digit("single", 0, 1'b1);
    check("to d3", obs(), pack(1'b0, 2'd3, 4'b0111));
    repeat (DIV) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en low idle", obs(), pack(1'b0, 2'd3, 4'hF));
    @(negedge clk);
    check("en low hold", obs(), pack(1'b0, 2'd3, 4'hF));
    en = 1'b1;
    @(negedge clk);
    check("en rise latency", obs(), pack(1'b0, 2'd3, 4'b0111));

    $display("phase: async reset mid-dwell");
    #2 rst_n = 1'b0;
    #1 check("async reset", obs(), pack(1'b0, 2'd0, 4'hF));
    @(negedge clk);
    digit_mask = 4'hF;
    rst_n = 1'b1;
    @(negedge clk);
    check("resync dark", obs(), pack(1'b0, 2'd0, 4'hF));
    wait_lit("rerelease");
    expect_digit("post", 0, 1'b0);
    expect_digit("post", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
